spi_reg_if: RTL and testbench

- SPI target front-end that converts SPI frames into single-cycle register accesses for the register bank.
- Sits directly upstream of the register bank.
  - Drives the bank's `wr_rdn`, `addr`, `wdata` and `we` inputs.
  - Consumes the bank's `rdata` output for reads.
- SPI mode 0 (CPOL=0, CPHA=0), MSB first.
- All SPI pins are oversampled in the `clk` domain. No logic is clocked by `spi_sclk`.

---
 rtl/spi_reg_if.sv | 208 ++++++++++++++++++++
 tb/tb_spi_reg_if.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/spi_reg_if.sv
// spi_reg_if: SPI mode-0 target that turns 1+ADDR_W+REG_W bit frames into
// single-cycle register bank accesses. Every SPI pin is oversampled in clk.
// Optional build macro SPI_FRAME_ERR_EN adds the frame_err output.
module spi_reg_if #(
  parameter int unsigned REG_W       = 8,
  parameter int unsigned ADDR_W      = 7,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic              ena,
  input  logic              spi_cs_n,
  input  logic              spi_sclk,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              wr_rdn,
  output logic [ADDR_W-1:0] addr,
  output logic [REG_W-1:0]  wdata,
  output logic              we,
  input  logic [REG_W-1:0]  rdata
`ifdef SPI_FRAME_ERR_EN
  ,
  output logic              frame_err
`endif
);

  localparam int unsigned FRAME_W = 1 + ADDR_W + REG_W;
  localparam int unsigned CNT_W   = $clog2(FRAME_W + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CMD,
    S_DATA,
    S_DONE
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;

  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic                   r_sclk_d;

  logic                   w_cs_n;
  logic                   w_sclk;
  logic                   w_mosi;
  logic                   w_rise;
  logic                   w_fall;
  logic                   w_abort;
  logic                   w_addr_done;
  logic                   w_frame_done;

  logic [CNT_W-1:0]       r_cnt;
  logic                   r_wr_rdn;
  logic [ADDR_W-1:0]      r_addr;
  logic [REG_W-1:0]       r_wdata;
  logic                   r_we;
  logic [REG_W-2:0]       r_data_sr;
  logic [REG_W-1:0]       w_data_nxt;
  logic [REG_W-1:0]       r_miso_sr;
  logic                   r_load;

  assign w_cs_n     = r_cs_sync[SYNC_STAGES-1];
  assign w_sclk     = r_sclk_sync[SYNC_STAGES-1];
  assign w_mosi     = r_mosi_sync[SYNC_STAGES-1];
  assign w_rise     = w_sclk & ~r_sclk_d;
  assign w_fall     = ~w_sclk & r_sclk_d;
  assign w_data_nxt = {r_data_sr, w_mosi};

  // Synchronize the SPI pins into clk and keep a delayed sclk for edge detect
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_cs_sync   <= '1;
      r_sclk_sync <= '0;
      r_mosi_sync <= '0;
      r_sclk_d    <= 1'b0;
    end else begin
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], spi_cs_n};
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], spi_sclk};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      r_sclk_d    <= w_sclk;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state plus the address-complete / frame-complete qualifiers
  always_comb begin
    w_state_nxt  = r_state;
    w_abort      = (r_state != S_IDLE) && (w_cs_n || !ena);
    w_addr_done  = 1'b0;
    w_frame_done = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_cs_n && ena) w_state_nxt = S_CMD;
      end
      S_CMD: begin
        if (w_abort) begin
          w_state_nxt = S_IDLE;
        end else if (w_rise && (r_cnt == CNT_W'(ADDR_W))) begin
          w_addr_done = 1'b1;
          w_state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        if (w_abort) begin
          w_state_nxt = S_IDLE;
        end else if (w_rise && (r_cnt == CNT_W'(FRAME_W - 1))) begin
          w_frame_done = 1'b1;
          w_state_nxt  = S_DONE;
        end
      end
      S_DONE: begin
        if (w_abort) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Frame datapath: bit counter, command/address capture, data shift,
  // write strobe and MISO shifter. The fall that directly follows the last
  // address rise must not shift MISO, so shifting waits for the first data rise.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_cnt     <= '0;
      r_wr_rdn  <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_we      <= 1'b0;
      r_data_sr <= '0;
      r_miso_sr <= '0;
      r_load    <= 1'b0;
    end else begin
      r_we   <= 1'b0;
      r_load <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_cnt     <= '0;
          r_miso_sr <= '0;
        end
        S_CMD: begin
          if (!w_abort && w_rise) begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == '0) begin
              r_wr_rdn <= w_mosi;
            end else begin
              r_addr <= {r_addr[ADDR_W-2:0], w_mosi};
            end
            if (w_addr_done) r_load <= ~r_wr_rdn;
          end
        end
        S_DATA: begin
          if (!w_abort) begin
            if (r_load) begin
              r_miso_sr <= rdata;
            end else if (w_fall && (r_cnt > CNT_W'(ADDR_W + 1))) begin
              r_miso_sr <= {r_miso_sr[REG_W-2:0], 1'b0};
            end
            if (w_rise) begin
              r_cnt     <= r_cnt + 1'b1;
              r_data_sr <= w_data_nxt[REG_W-2:0];
              if (w_frame_done && r_wr_rdn) begin
                r_wdata <= w_data_nxt;
                r_we    <= 1'b1;
              end
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

`ifdef SPI_FRAME_ERR_EN
  logic r_frame_err;

  // Sticky error: chip select lost mid-frame, or clock rises past the frame end
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_frame_err <= 1'b0;
    end else if (w_frame_done) begin
      r_frame_err <= 1'b0;
    end else if (((r_state == S_CMD) || (r_state == S_DATA)) && w_cs_n) begin
      r_frame_err <= 1'b1;
    end else if ((r_state == S_DONE) && !w_abort && w_rise) begin
      r_frame_err <= 1'b1;
    end
  end

  assign frame_err = r_frame_err;
`endif

  assign wr_rdn   = r_wr_rdn;
  assign addr     = r_addr;
  assign wdata    = r_wdata;
  assign we       = r_we;
  assign spi_miso = ((r_state == S_DATA) && !r_wr_rdn) ? r_miso_sr[REG_W-1] : 1'b0;

endmodule

// File: tb/tb_spi_reg_if.sv
// Directed bench for spi_reg_if: acts as SPI controller and register bank.
module tb_spi_reg_if;

  localparam int HALF = 8;

  logic       clk = 1'b0;
  logic       rstb;
  logic       ena;
  logic       spi_cs_n;
  logic       spi_sclk;
  logic       spi_mosi;
  logic       spi_miso;
  logic       wr_rdn;
  logic [6:0] addr;
  logic [7:0] wdata;
  logic       we;
  logic [7:0] rdata;
`ifdef SPI_FRAME_ERR_EN
  logic       frame_err;
`endif

  int         n_chk  = 0;
  int         n_pass = 0;
  int         we_cnt = 0;
  logic [6:0] cap_addr  = '0;
  logic [7:0] cap_wdata = '0;
  logic       cap_wr    = 1'b0;
  logic       miso_hi   = 1'b0;
  logic [7:0] mb;
  int         we_base;

  spi_reg_if #(
    .REG_W      (8),
    .ADDR_W     (7),
    .SYNC_STAGES(2)
  ) dut (
    .clk      (clk),
    .rstb     (rstb),
    .ena      (ena),
    .spi_cs_n (spi_cs_n),
    .spi_sclk (spi_sclk),
    .spi_mosi (spi_mosi),
    .spi_miso (spi_miso),
    .wr_rdn   (wr_rdn),
    .addr     (addr),
    .wdata    (wdata),
    .we       (we),
    .rdata    (rdata)
`ifdef SPI_FRAME_ERR_EN
    ,
    .frame_err(frame_err)
`endif
  );

  always #5 clk = ~clk;

  // Observe write strobes and any MISO activity on the falling edge
  always @(negedge clk) begin
    if (we) begin
      we_cnt    <= we_cnt + 1;
      cap_addr  <= addr;
      cap_wdata <= wdata;
      cap_wr    <= wr_rdn;
    end
    if (spi_miso) miso_hi <= 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic pulse(input logic b, output logic m);
    @(negedge clk);
    spi_mosi = b;
    repeat (HALF) @(negedge clk);
    m = spi_miso;
    spi_sclk = 1'b1;
    repeat (HALF) @(negedge clk);
    spi_sclk = 1'b0;
  endtask

  // Full frame of n pulses; bits beyond 16 are sent as 1. Returns MISO
  // sampled ahead of data rises 9..16, MSB first.
  task automatic frame(input logic [15:0] f, input int n, output logic [7:0] mbits);
    logic m;
    logic b;
    mbits = '0;
    @(negedge clk);
    spi_cs_n = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int i = 0; i < n; i++) begin
      b = (i < 16) ? f[15-i] : 1'b1;
      pulse(b, m);
      if (i >= 8 && i < 16) mbits[15-i] = m;
    end
    repeat (HALF) @(negedge clk);
    spi_cs_n = 1'b1;
    repeat (2 * HALF) @(negedge clk);
  endtask

  initial begin
    logic m;
    rstb     = 1'b0;
    ena      = 1'b1;
    spi_cs_n = 1'b1;
    spi_sclk = 1'b0;
    spi_mosi = 1'b0;
    rdata    = 8'h5A;
    repeat (4) @(negedge clk);
    chk("rst_miso",  32'(spi_miso), 32'h0);
    chk("rst_wr_rdn", 32'(wr_rdn),  32'h0);
    chk("rst_addr",  32'(addr),     32'h0);
    chk("rst_wdata", 32'(wdata),    32'h0);
    chk("rst_we",    32'(we),       32'h0);
    rstb = 1'b1;
    repeat (4) @(negedge clk);

    // Disabled block ignores a complete write frame
    ena = 1'b0;
    frame(16'h83A5, 16, mb);
    chk("ena0_we",    32'(we_cnt), 32'd0);
    chk("ena0_addr",  32'(addr),   32'h0);
    chk("ena0_wdata", 32'(wdata),  32'h0);
    ena = 1'b1;
    repeat (4) @(negedge clk);

    // Write 1, 0000011, 10100101
    miso_hi = 1'b0;
    frame(16'h83A5, 16, mb);
    chk("wr_we_cnt", 32'(we_cnt),    32'd1);
    chk("wr_addr",   32'(cap_addr),  32'h03);
    chk("wr_wdata",  32'(cap_wdata), 32'hA5);
    chk("wr_wr_rdn", 32'(cap_wr),    32'h1);
    chk("wr_miso",   32'(miso_hi),   32'h0);
    chk("wr_hold",   32'(wdata),     32'hA5);

    // Read 0, 1000010 with rdata 0x5A
    we_base = we_cnt;
    frame(16'h4200, 16, mb);
    chk("rd_addr",   32'(addr),             32'h42);
    chk("rd_wr_rdn", 32'(wr_rdn),           32'h0);
    chk("rd_miso",   32'(mb),               32'h5A);
    chk("rd_no_we",  32'(we_cnt - we_base), 32'd0);

    // Abort after 10 bits, then a good write 0x01 / 0x3C
    we_base = we_cnt;
    frame(16'h85FF, 10, mb);
    chk("ab_no_we", 32'(we_cnt - we_base), 32'd0);
    chk("ab_wdata", 32'(wdata),            32'hA5);
`ifdef SPI_FRAME_ERR_EN
    chk("ab_ferr",  32'(frame_err),        32'h1);
`endif
    frame(16'h813C, 16, mb);
    chk("rt_we_cnt", 32'(we_cnt - we_base), 32'd1);
    chk("rt_addr",   32'(cap_addr),         32'h01);
    chk("rt_wdata",  32'(wdata),            32'h3C);
`ifdef SPI_FRAME_ERR_EN
    chk("rt_ferr",   32'(frame_err),        32'h0);
`endif

    // Overlong write: 20 pulses, extra bits are ones
    we_base = we_cnt;
    frame(16'h8796, 20, mb);
    chk("ol_we_cnt", 32'(we_cnt - we_base), 32'd1);
    chk("ol_addr",   32'(cap_addr),         32'h07);
    chk("ol_wdata",  32'(wdata),            32'h96);
`ifdef SPI_FRAME_ERR_EN
    chk("ol_ferr",   32'(frame_err),        32'h1);
`endif

    // Reset pulsed in the middle of a read after 12 bits
    @(negedge clk);
    spi_cs_n = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int i = 0; i < 12; i++) pulse(((16'h4200 >> (15 - i)) & 16'h1) != 16'h0, m);
    repeat (HALF) @(negedge clk);
    chk("mr_miso_pre", 32'(spi_miso), 32'h1);
    rstb = 1'b0;
    #1;
    chk("mr_miso", 32'(spi_miso), 32'h0);
    chk("mr_we",   32'(we),       32'h0);
    chk("mr_addr", 32'(addr),     32'h0);
    @(negedge clk);
    spi_cs_n = 1'b1;
    repeat (4) @(negedge clk);
    rstb = 1'b1;
    repeat (2 * HALF) @(negedge clk);
    we_base = we_cnt;
    frame(16'h4200, 16, mb);
    chk("mr_rd_addr", 32'(addr),             32'h42);
    chk("mr_rd_miso", 32'(mb),               32'h5A);
    chk("mr_rd_we",   32'(we_cnt - we_base), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
